uart_wb_host: RTL and testbench
===============================

# uart_wb_host

WISHBONE initiator that drives the MiniUART slave on behalf of a byte-stream client such as the calculator front end. It polls the UART line-status register, writes queued transmit bytes to the data register when the transmitter is idle, and reads received bytes into a local FIFO. Optionally it programs both baud divisors after reset. It sits between CPU-independent logic and the UART, so no software polling loop is needed.

## Interface
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; must be a power of two ≥ 2.
- INIT_DIV, 0: 1 = write DIVR_INIT/DIVT_INIT to the UART after reset; 0 = leave the UART reset defaults.
- DIVR_INIT, 16'd0: receive divisor written when INIT_DIV=1.
- DIVT_INIT, 16'd0: transmit divisor written when INIT_DIV=1.
- CLK_I  in  1  clock, shared with the UART.
- RST_I  in  1  asynchronous, active-high reset.
- ADR_O  out  [4:2]  word address: 3'd0 DATA, 3'd1 LSR, 3'd2 DIVR, 3'd3 DIVT.
- DAT_O  out  32  write data.
- DAT_I  in  32  read data.
- STB_O  out  1  strobe.
- WE_O  out  1  write enable.
- ACK_I  in  1  acknowledge; may be combinational from STB_O.
- tx_data  in  8  byte to send.
- tx_valid  in  1  client offers tx_data.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of the RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  client consumes rx_data.

## Operation
- LSR fields: bit0 = rs (received byte available); bit5 = ts (transmitter idle).
- A bus access holds STB_O, ADR_O, WE_O and DAT_O stable until the cycle ACK_I=1. It completes on that clock edge, and read data is captured on the same edge.
- FSM states:
  - INIT_R: write DIVR_INIT to DIVR.
  - INIT_T: write DIVT_INIT to DIVT.
  - POLL: read LSR into lsr_q.
  - DECIDE.
  - RD: read DATA.
  - WR: write DATA with DAT_O = {24'b0, tx_head}.
  - GUARD.
- Transitions:
  - Reset → INIT_R if INIT_DIV, else POLL.
  - INIT_R → INIT_T → POLL.
  - POLL → DECIDE.
  - DECIDE → RD if lsr_q[0] && RX FIFO not full. Else → WR if lsr_q[5] && TX FIFO not empty. Else → POLL.
  - RD → GUARD with 1 idle cycle. WR → GUARD with 2 idle cycles. GUARD → POLL.
- RX has priority over TX in DECIDE.
- When the RX FIFO is full, DATA is not read. The byte stays in the UART with rs held, so the host never drops data.
- GUARD exists because the UART updates ts/rs one to two cycles after an access. This prevents a stale LSR from causing a double write or a double read.
- TX FIFO:
  - Push when tx_valid && tx_ready.
  - Pop on WR completion.
  - Push and pop in the same cycle leave the count unchanged.
- RX FIFO:
  - Push on RD completion with DAT_I[7:0].
  - Pop when rx_valid && rx_ready.
  - Push and pop in the same cycle leave the count unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally, and full/empty are decided by the MSB compare.

## Timing
- Reset values:
  - STB_O=0, WE_O=0, ADR_O=0, DAT_O=0.
  - tx_ready=1, rx_valid=0, rx_data=0.
  - FIFOs empty; lsr_q=0.
- STB_O is low in DECIDE and GUARD. Every other state asserts it.
- Best-case TX latency, tx_valid accepted to DATA write strobe, with the FSM in POLL and ts=1: 3 cycles (POLL, DECIDE, WR).
- Best-case RX latency, rs high to byte visible on rx_valid: 4 cycles.
- RST_I mid-access: STB_O drops asynchronously, both FIFOs flush, and the FSM restarts at INIT_R or POLL. No partial write is retried.
- ACK_I held low: the FSM waits indefinitely in the access state. No timeout.

## Structure
- Shared package/header: LSR bit indices and address codes, taken from the existing UART header constants, plus the FSM state encoding.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH), instantiated twice.

## Test plan
- Reset with INIT_DIV=1, DIVR_INIT=16'h0145, DIVT_INIT=16'h028B → writes to ADR 2 then 3 with those values, then LSR polling begins.
- Push 8'h41 with UART ts=1 → one DATA write with DAT_O=32'h00000041, WE_O=1, followed by 2 GUARD cycles before the next LSR read.
- Model rs=1 with DATA=8'h5A, rx_ready=1 → rx_valid rises with rx_data=8'h5A, and exactly one DATA read occurs.
- Fill the RX FIFO (rx_ready=0) with 4 bytes while rs stays 1 → no further DATA reads. Raise rx_ready → the 5th byte is read after the first pop.
- rs=1 and ts=1 with a TX byte pending → RD precedes WR; both complete with no lost byte.
- Assert RST_I while STB_O is high in WR → STB_O=0 immediately, tx_ready=1, no DATA write after release.

Source files
------------

// File: rtl/uart_wb_host_pkg.sv
// Shared constants for the MiniUART WISHBONE host: LSR bit positions,
// register word addresses and the host FSM encoding.
package uart_wb_host_pkg;

  localparam int unsigned LSR_RS = 0;
  localparam int unsigned LSR_TS = 5;

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_LSR  = 3'd1;
  localparam logic [2:0] ADR_DIVR = 3'd2;
  localparam logic [2:0] ADR_DIVT = 3'd3;

  typedef enum logic [2:0] {
    ST_INIT_R,
    ST_INIT_T,
    ST_POLL,
    ST_DECIDE,
    ST_RD,
    ST_WR,
    ST_GUARD
  } state_e;

  // States that drive a bus access
  function automatic logic is_access(input state_e s);
    return (s != ST_DECIDE) && (s != ST_GUARD);
  endfunction

endpackage

// File: rtl/uart_wb_host_sync_fifo.sv
// Register-based synchronous FIFO with extra-MSB pointers for full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// WISHBONE initiator for the MiniUART: polls LSR, moves bytes between the
// UART data register and local TX/RX FIFOs, optionally programs divisors.
module uart_wb_host
  import uart_wb_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          INIT_DIV   = 1'b0,
  parameter logic [15:0] DIVR_INIT  = 16'd0,
  parameter logic [15:0] DIVT_INIT  = 16'd0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [4:2]  ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
);

  state_e      state_q, state_d;
  logic        guard_q, guard_d;
  logic [7:0]  lsr_q, lsr_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  logic       done;
  logic       tx_pop, rx_push;
  logic [7:0] tx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       unused_c;

  assign unused_c = ^{DAT_I[31:8], lsr_q[7:6], lsr_q[4:1]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK_I), .rst(RST_I), .push(tx_valid), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK_I), .rst(RST_I), .push(rx_push), .push_data(DAT_I[7:0]),
    .pop(rx_ready), .head(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign STB_O    = stb_q;
  assign WE_O     = we_q;
  assign ADR_O    = adr_q;
  assign DAT_O    = dat_q;

  // Next state, then bus outputs registered from the next state so they
  // hold steady for the whole access
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    lsr_d   = lsr_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    done    = stb_q && ACK_I;

    case (state_q)
      ST_INIT_R: if (done) state_d = ST_INIT_T;
      ST_INIT_T: if (done) state_d = ST_POLL;
      ST_POLL: begin
        if (done) begin
          lsr_d   = DAT_I[7:0];
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (lsr_q[LSR_RS] && !rx_full)       state_d = ST_RD;
        else if (lsr_q[LSR_TS] && !tx_empty) state_d = ST_WR;
        else                                 state_d = ST_POLL;
      end
      ST_RD: begin
        if (done) begin
          rx_push = 1'b1;
          guard_d = 1'b0;
          state_d = ST_GUARD;
        end
      end
      ST_WR: begin
        if (done) begin
          tx_pop  = 1'b1;
          guard_d = 1'b1;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_q) guard_d = 1'b0;
        else         state_d = ST_POLL;
      end
      default: state_d = ST_POLL;
    endcase

    stb_d = is_access(state_d);
    we_d  = 1'b0;
    adr_d = '0;
    dat_d = '0;
    case (state_d)
      ST_INIT_R: begin
        we_d  = 1'b1;
        adr_d = ADR_DIVR;
        dat_d = {16'h0, DIVR_INIT};
      end
      ST_INIT_T: begin
        we_d  = 1'b1;
        adr_d = ADR_DIVT;
        dat_d = {16'h0, DIVT_INIT};
      end
      ST_POLL: adr_d = ADR_LSR;
      ST_RD:   adr_d = ADR_DATA;
      ST_WR: begin
        we_d  = 1'b1;
        adr_d = ADR_DATA;
        dat_d = {24'h0, tx_head};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= INIT_DIV ? ST_INIT_R : ST_POLL;
      guard_q <= 1'b0;
      lsr_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      lsr_q   <= lsr_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Directed and randomized bench for uart_wb_host against a small MiniUART
// model with lagged LSR flags; byte streams are checked end to end.
module tb_uart_wb_host;

  localparam logic [15:0] DIVR = 16'h0145;
  localparam logic [15:0] DIVT = 16'h028B;
  localparam int          NRND = 24;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [4:2]  ADR_O;
  logic [31:0] DAT_O, DAT_I;
  logic        STB_O, WE_O, ACK_I;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        ack_en, hold_wr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  adr;
    logic        we;
    logic [31:0] dat;
    int          cyc;
  } acc_t;

  acc_t       bus_log[$];
  logic [7:0] uart_rxq[$];
  logic [7:0] uart_txlog[$];
  logic [7:0] rx_got[$];
  int         rx_got_cyc[$];
  logic [15:0] divr_reg = 16'h0, divt_reg = 16'h0;
  int          ts_busy = 0;
  logic        rs_q = 1'b0, ts_q = 1'b1;
  logic [7:0]  data_q = 8'h00;

  uart_wb_host #(
    .FIFO_DEPTH(4), .INIT_DIV(1'b1), .DIVR_INIT(DIVR), .DIVT_INIT(DIVT)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 CLK_I = ~CLK_I;

  assign ACK_I = STB_O && ack_en && !(hold_wr && WE_O && ADR_O == 3'd0);
  assign DAT_I = (ADR_O == 3'd0) ? {24'hA5A5A5, data_q} :
                 (ADR_O == 3'd1) ? {26'h0, ts_q, 4'h0, rs_q} :
                 (ADR_O == 3'd2) ? {16'h0, divr_reg} : {16'h0, divt_reg};

  // UART model: flags and data register lag the internal state by a cycle
  always @(posedge CLK_I) begin
    rs_q   <= (uart_rxq.size() > 0);
    data_q <= (uart_rxq.size() > 0) ? uart_rxq[0] : 8'h00;
    ts_q   <= (ts_busy == 0);
    if (ts_busy > 0) ts_busy--;
    if (STB_O && ACK_I) begin
      bus_log.push_back('{ADR_O, WE_O, DAT_O, cyc});
      if (WE_O) begin
        if (ADR_O == 3'd0) begin
          uart_txlog.push_back(DAT_O[7:0]);
          ts_busy = 3;
        end else if (ADR_O == 3'd2) divr_reg = DAT_O[15:0];
        else if (ADR_O == 3'd3) divt_reg = DAT_O[15:0];
      end else if (ADR_O == 3'd0 && uart_rxq.size() > 0) begin
        void'(uart_rxq.pop_front());
      end
    end
    if (rx_valid && rx_ready) begin
      rx_got.push_back(rx_data);
      rx_got_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_acc(input int from, input logic [2:0] adr, input logic we, input int nth);
    int n = 0;
    for (int i = from; i < bus_log.size(); i++)
      if (bus_log[i].adr == adr && bus_log[i].we == we) begin
        if (n == nth) return i;
        n++;
      end
    return -1;
  endfunction

  function automatic int count_acc(input int from, input logic [2:0] adr, input logic we);
    int n = 0;
    for (int i = from; i < bus_log.size(); i++)
      if (bus_log[i].adr == adr && bus_log[i].we == we) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, m, w, r, g0, t0, r0, tx_i, rx_i, errs;
    logic acc;
    logic [7:0] b[5];
    logic [7:0] rb, tb_byte;
    logic [7:0] tgen[NRND];
    logic [7:0] rgen[NRND];

    RST_I = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    ack_en = 1'b1; hold_wr = 1'b0;
    #3;
    check("rst_stb", STB_O, 0);
    check("rst_we", WE_O, 0);
    check("rst_adr", ADR_O, 0);
    check("rst_dat", DAT_O, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    tick(); tick();

    // Divisor programming then polling
    RST_I = 1'b0;
    k = 0;
    while (bus_log.size() < 3 && k < 30) begin tick(); k++; end
    check("init_timeout", bus_log.size() >= 3, 1);
    check("init0_adr", bus_log[0].adr, 2);
    check("init0_we", bus_log[0].we, 1);
    check("init0_dat", bus_log[0].dat, 32'h0145);
    check("init1_adr", bus_log[1].adr, 3);
    check("init1_dat", bus_log[1].dat, 32'h028B);
    check("init2_lsr", {bus_log[2].adr, bus_log[2].we}, {3'd1, 1'b0});

    // Single TX byte
    m = bus_log.size();
    tx_data = 8'h41; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    k = 0;
    while (count_acc(m, 3'd0, 1'b1) < 1 && k < 40) begin tick(); k++; end
    repeat (20) tick();
    w = find_acc(m, 3'd0, 1'b1, 0);
    check("tx_found", w >= 0, 1);
    if (w >= 0) begin
      check("tx_dat", bus_log[w].dat, 32'h00000041);
      check("tx_next_lsr", bus_log[w+1].adr, 1);
      check("tx_guard_gap", bus_log[w+1].cyc - bus_log[w].cyc, 3);
    end
    check("tx_count", count_acc(m, 3'd0, 1'b1), 1);

    // Single RX byte
    rx_ready = 1'b1;
    m = bus_log.size();
    uart_rxq.push_back(8'h5A);
    k = 0;
    while (rx_got.size() < 1 && k < 40) begin tick(); k++; end
    repeat (20) tick();
    check("rx_first", rx_got.size() >= 1 ? rx_got[0] : 8'hxx, 8'h5A);
    check("rx_reads", count_acc(m, 3'd0, 1'b0), 1);
    r = find_acc(m, 3'd0, 1'b0, 0);
    if (r >= 0) check("rx_guard_gap", bus_log[r+1].cyc - bus_log[r].cyc, 2);

    // RX FIFO full back-pressure
    rx_ready = 1'b0;
    m = bus_log.size();
    g0 = rx_got.size();
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom_range(255, 0));
      uart_rxq.push_back(b[i]);
    end
    repeat (60) tick();
    check("full_reads", count_acc(m, 3'd0, 1'b0), 4);
    check("full_uart_left", uart_rxq.size(), 1);
    check("full_head", rx_data, b[0]);
    rx_ready = 1'b1;
    k = 0;
    while (rx_got.size() < g0 + 5 && k < 80) begin tick(); k++; end
    check("full_drain_timeout", rx_got.size() >= g0 + 5, 1);
    errs = 0;
    for (int i = 0; i < 5; i++) if (rx_got[g0+i] !== b[i]) errs++;
    check("full_bytes", errs, 0);
    r = find_acc(m, 3'd0, 1'b0, 4);
    check("fifth_after_pop", (r >= 0) && (bus_log[r].cyc > rx_got_cyc[g0]), 1);

    // RX priority over TX
    ack_en = 1'b0;
    repeat (8) tick();
    m = bus_log.size();
    g0 = rx_got.size();
    t0 = uart_txlog.size();
    rb = 8'($urandom_range(255, 0));
    tb_byte = 8'($urandom_range(255, 0));
    uart_rxq.push_back(rb);
    tx_data = tb_byte; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    ack_en = 1'b1;
    k = 0;
    while ((rx_got.size() <= g0 || uart_txlog.size() <= t0) && k < 60) begin tick(); k++; end
    r = find_acc(m, 3'd0, 1'b0, 0);
    w = find_acc(m, 3'd0, 1'b1, 0);
    check("prio_order", (r >= 0) && (w > r), 1);
    check("prio_rx_byte", rx_got.size() > g0 ? rx_got[g0] : 8'hxx, rb);
    check("prio_tx_byte", uart_txlog.size() > t0 ? uart_txlog[t0] : 8'hxx, tb_byte);

    // Randomized streams with random ACK stalls and client back-pressure
    for (int i = 0; i < NRND; i++) begin
      tgen[i] = 8'($urandom_range(255, 0));
      rgen[i] = 8'($urandom_range(255, 0));
    end
    g0 = rx_got.size();
    t0 = uart_txlog.size();
    tx_i = 0; rx_i = 0;
    for (int c = 0; c < 3000; c++) begin
      if (uart_txlog.size() >= t0 + NRND && rx_got.size() >= g0 + NRND) break;
      if (!tx_valid && tx_i < NRND && $urandom_range(1, 0) == 1) begin
        tx_data = tgen[tx_i]; tx_valid = 1'b1;
      end
      if (rx_i < NRND && $urandom_range(3, 0) == 0) begin
        uart_rxq.push_back(rgen[rx_i]); rx_i++;
      end
      ack_en = ($urandom_range(3, 0) != 0);
      rx_ready = ($urandom_range(1, 0) == 1);
      acc = tx_valid && tx_ready;
      tick();
      if (acc) begin tx_valid = 1'b0; tx_i++; end
    end
    ack_en = 1'b1; rx_ready = 1'b1;
    check("rnd_tx_count", uart_txlog.size() - t0, NRND);
    check("rnd_rx_count", rx_got.size() - g0, NRND);
    errs = 0;
    for (int i = 0; i < NRND; i++) if (uart_txlog.size() > t0 + i && uart_txlog[t0+i] !== tgen[i]) errs++;
    check("rnd_tx_stream", errs, 0);
    errs = 0;
    for (int i = 0; i < NRND; i++) if (rx_got.size() > g0 + i && rx_got[g0+i] !== rgen[i]) errs++;
    check("rnd_rx_stream", errs, 0);

    // Reset in the middle of a DATA write
    repeat (10) tick();
    hold_wr = 1'b1;
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    k = 0;
    while (!(STB_O && WE_O && ADR_O == 3'd0) && k < 40) begin tick(); k++; end
    check("mid_wr_reached", STB_O && WE_O && ADR_O == 3'd0, 1);
    m = bus_log.size();
    RST_I = 1'b1;
    #1;
    check("mid_rst_stb", STB_O, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    tick(); tick();
    hold_wr = 1'b0;
    RST_I = 1'b0;
    repeat (40) tick();
    check("mid_no_write", count_acc(m, 3'd0, 1'b1), 0);
    check("mid_reinit", bus_log.size() > m ? bus_log[m].adr : 3'bxxx, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
